keypad_hit_conditioner: RTL

//  Upstream input stage for the whack-a-mole game core. Synchronises and debounces the 8 raw

---
 rtl/keypad_hit_conditioner.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_hit_conditioner.sv
// keypad_hit_conditioner
//   Input stage for the whack-a-mole game core. Each raw key is synchronised
//   through two flops and debounced. A rising debounced level becomes a
//   one-hot hit token. Tokens are held until the game core takes them on its
//   slow tick through a valid/ready handshake, so a press made between ticks
//   is not lost.
//
// Build option
//   HIT_FIFO_EN : when defined, the single hold register becomes a FIFO of
//                 FIFO_DEPTH entries. FIFO_DEPTH must be a power of 2, >= 2.
//                 When undefined, FIFO_DEPTH is ignored.
//
// Ports
//   clk          system clock
//   RESET_N      asynchronous reset, active low
//   keypad       raw keys, asynchronous, active high
//   clear        synchronous flush of pending tokens and drop_cnt
//   hit_ready    consumer takes the presented token on this edge
//   hit_valid    a token is presented
//   hit_code     one-hot token; zero when hit_valid is low
//   hit_idx      binary index of the hit_code bit; zero when hit_valid is low
//   key_level    debounced key levels
//   multi_press  one-cycle pulse: more than one key rose on the same edge
//   drop_cnt     number of dropped presses; saturates at 255
module keypad_hit_conditioner #(
  parameter int unsigned NKEYS           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [NKEYS-1:0] keypad,
  input  logic             clear,
  input  logic             hit_ready,
  output logic             hit_valid,
  output logic [NKEYS-1:0] hit_code,
  output logic [2:0]       hit_idx,
  output logic [NKEYS-1:0] key_level,
  output logic             multi_press,
  output logic [7:0]       drop_cnt
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned CW      = $clog2(NKEYS + 1);

  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] level_d;
  logic [15:0]      cnt [NKEYS];

  logic [NKEYS-1:0] rise;
  logic [NKEYS-1:0] token;
  logic [CW-1:0]    nrise;
  logic             any_rise;
  logic             push;
  logic             pop;
  logic             accept;
  logic             dropped;
  logic             buf_free;
  logic             valid;
  logic [15:0]      drop_inc;
  logic [15:0]      drop_sum;
  logic [7:0]       drop_next;

  // Two-flop synchroniser; nothing downstream looks at raw keypad.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keypad;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive
  // mismatched edge; any agreement restarts the count.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      level   <= '0;
      level_d <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else begin
      level_d <= level;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (sync2[i] != level[i]) begin
          if (cnt[i] == DB_LAST) begin
            level[i] <= ~level[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 16'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign key_level = level;

  // Rises are taken from the registered level so the push lands one edge
  // after the level flips (DEBOUNCE_CYCLES+3 edges end to end).
  assign rise = level & ~level_d;

  always_comb begin
    token = '0;
    nrise = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (rise[i]) begin
        if (nrise == '0) token[i] = 1'b1;
        nrise = nrise + 1'b1;
      end
    end
  end

  assign any_rise = (nrise != '0);
  assign push     = any_rise & ~clear;
  assign pop      = valid & hit_ready;
  assign accept   = push & (buf_free | pop);
  assign dropped  = push & ~accept;

  // Extra simultaneous rises plus a rejected push, added with saturation.
  always_comb begin
    drop_inc = '0;
    if (any_rise) drop_inc = 16'(nrise) - 16'd1;
    if (dropped)  drop_inc = drop_inc + 16'd1;
    drop_sum  = {8'd0, drop_cnt} + drop_inc;
    drop_next = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      drop_cnt    <= '0;
      multi_press <= 1'b0;
    end else begin
      multi_press <= (nrise > CW'(1));
      if (clear) drop_cnt <= '0;
      else       drop_cnt <= drop_next;
    end
  end

`ifdef HIT_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [NKEYS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign valid    = (count != '0);
  assign buf_free = (count != (AW+1)'(FIFO_DEPTH));
  assign hit_code = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= token;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [NKEYS-1:0] hold;

  assign buf_free = ~valid;
  assign hit_code = valid ? hold : '0;

  // Accept covers both the empty case and replace-on-pop.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      hold  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      hold  <= '0;
      valid <= 1'b0;
    end else if (accept) begin
      hold  <= token;
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end
`endif

  assign hit_valid = valid;

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    hit_idx = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (hit_code[NKEYS-1-i]) hit_idx = 3'(NKEYS - 1 - i);
    end
  end

endmodule
